// File: rtl/regfile_pkg.sv
// Shared defaults and flattened-bus slicing helpers for the register file.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;

  // Low bit of lane idx in a flattened bus of width-wide lanes (lane 0 at LSB).
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set by issue, cleared by any write to that register.
// Latency: busy updates on clk rise; rbusy_o/iss_ready_o are combinational reads.
// Backpressure: none; issuing a busy register just keeps it busy.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int NUM_WR   = 2,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WR-1:0]    wen_i,
  input  logic [NUM_WR*AW-1:0] waddr_i,
  input  logic [NUM_RD*AW-1:0] raddr_i,
  input  logic                 iss_valid_i,
  input  logic [AW-1:0]        iss_rd_i,
  output logic [NUM_RD-1:0]    rbusy_o,
  output logic                 iss_ready_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [AW-1:0]    rd_a;
  logic             rd_b;

  // Next busy state: writes clear first, then an issue sets so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wen_i[i]) busy_d[waddr_i[slice_lo(i, AW) +: AW]] = 1'b0;
    end
    if (iss_valid_i && !(ZERO_REG != 0 && iss_rd_i == '0)) busy_d[iss_rd_i] = 1'b1;
  end

  // Busy bit register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Read-side busy flags, hidden when the forwarded write already satisfies the read.
  always_comb begin
    rbusy_o = '0;
    rd_a    = '0;
    rd_b    = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_a = raddr_i[slice_lo(k, AW) +: AW];
      rd_b = busy_q[rd_a];
      if (BYPASS != 0) begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (wen_i[i] && waddr_i[slice_lo(i, AW) +: AW] == rd_a) rd_b = 1'b0;
        end
      end
      rbusy_o[k] = rd_b;
    end
  end

  assign iss_ready_o = ~busy_q[iss_rd_i];

endmodule

// File: rtl/reg_file_scoreboard.sv
// Multi-port register file with write-to-read forwarding and a busy scoreboard.
// Latency: reads are combinational; writes and busy updates land on clk rise.
// Backpressure: none; iss_ready is advisory and issues are always accepted.
module reg_file_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_WR-1:0]            wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         iss_valid,
  input  logic [ADDR_WIDTH-1:0]        iss_rd,
  output logic                         iss_ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf_q [DEPTH];
  logic [NUM_WR-1:0]     wen_eff;
  logic [ADDR_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_v;

  // Writes are meaningless while reset is held; masking here also keeps them
  // off the forwarding path so reads stay zero during reset.
  assign wen_eff = wen & {NUM_WR{rst_n}};

  // Data array; later ports are applied last so the highest port wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) rf_q[a] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wen_eff[i] &&
            !(ZERO_REG != 0 && waddr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH] == '0)) begin
          rf_q[waddr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH]] <=
            wdata[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH];
        end
      end
    end
  end

  // Combinational read with optional forwarding of this cycle's winning write.
  always_comb begin
    rdata = '0;
    rd_a  = '0;
    rd_v  = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_a = raddr[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH];
      rd_v = rf_q[rd_a];
      if (BYPASS != 0) begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (wen_eff[i] && waddr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH] == rd_a)
            rd_v = wdata[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH];
        end
      end
      if (ZERO_REG != 0 && rd_a == '0) rd_v = '0;
      rdata[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH] = rd_v;
    end
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .NUM_WR   (NUM_WR),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .wen_i       (wen_eff),
    .waddr_i     (waddr),
    .raddr_i     (raddr),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .rbusy_o     (rbusy),
    .iss_ready_o (iss_ready)
  );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench: table of per-cycle vectors plus hand-written reset sequences.
// Latency: reads checked 1 time unit after inputs change, before the next rise.
// Backpressure: n/a.
module tb_reg_file_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wen;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [63:0] rdata_nb;
  logic [1:0]  rbusy_nb;
  logic        iss_ready_nb;

  int n_pass  = 0;
  int n_total = 0;

  reg_file_scoreboard #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready)
  );

  reg_file_scoreboard #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic        iv;
    logic [4:0]  ir;
    logic [31:0] e_rd0, e_rd1;
    logic [1:0]  e_rb;
    logic        e_rdy;
    logic [31:0] e_nb0;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  function automatic vec_t mk(input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic iv, input logic [4:0] ir,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [1:0] erb, input logic erdy, input logic [31:0] enb);
    vec_t v;
    v.wen = w; v.wa0 = a0; v.wa1 = a1; v.wd0 = d0; v.wd1 = d1;
    v.ra0 = r0; v.ra1 = r1; v.iv = iv; v.ir = ir;
    v.e_rd0 = e0; v.e_rd1 = e1; v.e_rb = erb; v.e_rdy = erdy; v.e_nb0 = enb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic iv, input logic [4:0] ir);
    wen = w; waddr = {a1, a0}; wdata = {d1, d0};
    raddr = {r1, r0}; iss_valid = iv; iss_rd = ir;
  endtask

  initial begin
    //        wen   wa0 wa1 wd0           wd1    ra0 ra1 iv ir  e_rd0         e_rd1         rb    rdy nb0
    vt[0]  = mk(2'b00, 0, 0, 32'h0,        32'h0,  0, 31, 0, 0, 32'h0,        32'h0,        2'b00, 1, 32'h0);
    vt[1]  = mk(2'b01, 5, 0, 32'hDEADBEEF, 32'h0,  5, 5,  0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1, 32'h0);
    vt[2]  = mk(2'b00, 0, 0, 32'h0,        32'h0,  5, 5,  0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1, 32'hDEADBEEF);
    vt[3]  = mk(2'b11, 7, 7, 32'h11,       32'h22, 7, 7,  0, 0, 32'h22,       32'h22,       2'b00, 1, 32'h0);
    vt[4]  = mk(2'b01, 0, 0, 32'hFF,       32'h0,  7, 0,  0, 0, 32'h22,       32'h0,        2'b00, 1, 32'h22);
    vt[5]  = mk(2'b00, 0, 0, 32'h0,        32'h0,  0, 7,  1, 3, 32'h0,        32'h22,       2'b00, 1, 32'h0);
    vt[6]  = mk(2'b00, 0, 0, 32'h0,        32'h0,  3, 0,  0, 3, 32'h0,        32'h0,        2'b01, 0, 32'h0);
    vt[7]  = mk(2'b01, 3, 0, 32'h1234,     32'h0,  3, 3,  1, 3, 32'h1234,     32'h1234,     2'b00, 0, 32'h0);
    vt[8]  = mk(2'b00, 0, 0, 32'h0,        32'h0,  3, 3,  0, 3, 32'h1234,     32'h1234,     2'b11, 0, 32'h1234);
    vt[9]  = mk(2'b00, 0, 0, 32'h0,        32'h0,  0, 3,  1, 0, 32'h0,        32'h1234,     2'b10, 1, 32'h0);
    vt[10] = mk(2'b00, 0, 0, 32'h0,        32'h0,  0, 3,  0, 0, 32'h0,        32'h1234,     2'b10, 1, 32'h0);
    vt[11] = mk(2'b01, 3, 0, 32'h5678,     32'h0,  3, 3,  0, 3, 32'h5678,     32'h5678,     2'b00, 0, 32'h1234);
    vt[12] = mk(2'b10, 0, 9, 32'h0,        32'hA5, 3, 9,  0, 3, 32'h5678,     32'hA5,       2'b00, 1, 32'h5678);
    vt[13] = mk(2'b00, 0, 0, 32'h0,        32'h0,  9, 9,  0, 9, 32'hA5,       32'hA5,       2'b00, 1, 32'hA5);

    rst_n = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 0);

    // Stimulus while held in reset must be ignored and outputs stay quiet.
    @(negedge clk);
    drive(2'b11, 4, 6, 32'h77, 32'h88, 4, 6, 1'b1, 4);
    #1;
    chk("in_reset_rdata0", rdata[31:0], 32'h0);
    chk("in_reset_rdata1", rdata[63:32], 32'h0);
    chk("in_reset_ready", {31'h0, iss_ready}, 32'h1);
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 0);
    rst_n = 1'b1;

    // Every address reads zero and idle after reset.
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      drive(2'b00, 0, 0, 0, 0, 5'(a), 5'(31 - a), 1'b0, 5'(a));
      #1;
      chk($sformatf("rst_rdata0[%0d]", a), rdata[31:0], 32'h0);
      chk($sformatf("rst_rdata1[%0d]", 31 - a), rdata[63:32], 32'h0);
      chk($sformatf("rst_rbusy[%0d]", a), {30'h0, rbusy}, 32'h0);
      chk($sformatf("rst_ready[%0d]", a), {31'h0, iss_ready}, 32'h1);
    end

    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      drive(vt[v].wen, vt[v].wa0, vt[v].wa1, vt[v].wd0, vt[v].wd1,
            vt[v].ra0, vt[v].ra1, vt[v].iv, vt[v].ir);
      #1;
      chk($sformatf("v%0d_rdata0", v), rdata[31:0], vt[v].e_rd0);
      chk($sformatf("v%0d_rdata1", v), rdata[63:32], vt[v].e_rd1);
      chk($sformatf("v%0d_rbusy", v), {30'h0, rbusy}, {30'h0, vt[v].e_rb});
      chk($sformatf("v%0d_ready", v), {31'h0, iss_ready}, {31'h0, vt[v].e_rdy});
      chk($sformatf("v%0d_nobypass_rdata0", v), rdata_nb[31:0], vt[v].e_nb0);
    end

    // Make r3 busy holding 0x1234, then assert reset between clock edges.
    @(negedge clk);
    drive(2'b01, 3, 0, 32'h1234, 0, 3, 0, 1'b1, 3);
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0, 3, 0, 1'b0, 3);
    #1;
    chk("pre_arst_rdata0", rdata[31:0], 32'h1234);
    chk("pre_arst_rbusy0", {31'h0, rbusy[0]}, 32'h1);
    chk("pre_arst_ready", {31'h0, iss_ready}, 32'h0);
    #2;
    rst_n = 1'b0;
    drive(2'b01, 3, 0, 32'h77, 0, 3, 0, 1'b1, 3);
    #1;
    chk("arst_rdata0", rdata[31:0], 32'h0);
    chk("arst_rbusy0", {31'h0, rbusy[0]}, 32'h0);
    chk("arst_ready", {31'h0, iss_ready}, 32'h1);
    @(posedge clk);
    #1;
    chk("arst_edge_rdata0", rdata[31:0], 32'h0);
    chk("arst_edge_ready", {31'h0, iss_ready}, 32'h1);

    // Release mid-cycle with idle inputs; nothing from before reset may survive.
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 3, 3, 1'b0, 3);
    @(negedge clk);
    #1;
    chk("post_rel_rdata0", rdata[31:0], 32'h0);
    chk("post_rel_rbusy", {30'h0, rbusy}, 32'h0);
    chk("post_rel_ready", {31'h0, iss_ready}, 32'h1);

    // Normal writes resume after release.
    @(negedge clk);
    drive(2'b01, 3, 0, 32'hCAFE, 0, 0, 0, 1'b0, 3);
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0, 3, 3, 1'b0, 3);
    #1;
    chk("post_rel_write", rdata[31:0], 32'hCAFE);
    chk("post_rel_write_nb", rdata_nb[31:0], 32'hCAFE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
